robot_remote: RTL and testbench

- Remote-control (operator panel) end of the robot drive link.
- Debounces five operator buttons and encodes them into the 3-bit move command and the motor-enable line sent to the robot controller.
- Consumes the robot's motor status and obstacle status. Manages engine start/stop with timeouts, and locks out forward motion after an obstacle report.

---
 rtl/robot_remote_pkg.sv | 35 +++
 rtl/robot_remote_if.sv | 12 +
 rtl/robot_remote_btn_debounce.sv | 40 ++++
 rtl/robot_remote.sv | 127 ++++++++++++
 tb/tb_robot_remote.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/robot_remote_pkg.sv
// rtl/robot_remote_pkg.sv - shared move codes, remote FSM states and move encoder
package robot_remote_pkg;

  localparam logic [2:0] MOVE_STOP  = 3'b000;
  localparam logic [2:0] MOVE_FWD   = 3'b111;
  localparam logic [2:0] MOVE_LEFT  = 3'b101;
  localparam logic [2:0] MOVE_RIGHT = 3'b110;
  localparam logic [2:0] MOVE_BACK  = 3'b011;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_STARTING,
    ST_ON,
    ST_STOPPING,
    ST_FAULT
  } remote_state_e;

  // Only a single pressed direction yields a command; ties mean stop.
  function automatic logic [2:0] encode_move(input logic fwd, input logic back,
                                             input logic left, input logic right,
                                             input logic fwd_locked);
    logic [2:0] n;
    logic [2:0] code;
    n    = {2'b0, fwd} + {2'b0, back} + {2'b0, left} + {2'b0, right};
    code = MOVE_STOP;
    if (n == 3'd1) begin
      if (fwd)       code = fwd_locked ? MOVE_STOP : MOVE_FWD;
      else if (back) code = MOVE_BACK;
      else if (left) code = MOVE_LEFT;
      else           code = MOVE_RIGHT;
    end
    return code;
  endfunction

endpackage

// File: rtl/robot_remote_if.sv
// rtl/robot_remote_if.sv - drive link between operator remote and robot controller
interface robot_remote_if;
  logic       motor_status_i;
  logic       tracker_status_i;
  logic       motor_on_o;
  logic [2:0] move_o;

  modport master (input motor_status_i, input tracker_status_i,
                  output motor_on_o, output move_o);
  modport slave  (output motor_status_i, output tracker_status_i,
                  input motor_on_o, input move_o);
endinterface

// File: rtl/robot_remote_btn_debounce.sv
// rtl/robot_remote_btn_debounce.sv - 2-flop synchronizer plus counting debouncer
module robot_remote_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic btn_i,
  output logic stable_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  always_comb begin
    sync_d   = {sync_q[0], btn_i};
    cnt_d    = '0;
    stable_d = stable_q;
    // The flip happens on the edge where the disagreement run would hit the limit.
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync_q[1];
      else                                   cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/robot_remote.sv
// rtl/robot_remote.sv - operator remote: button conditioning, engine FSM, obstacle lockout
module robot_remote
  import robot_remote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int START_TIMEOUT   = 8,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           btn_power_i,
  input  logic           btn_fwd_i,
  input  logic           btn_back_i,
  input  logic           btn_left_i,
  input  logic           btn_right_i,
  robot_remote_if.master link,
  output logic           led_power_o,
  output logic           led_obstacle_o,
  output logic           err_o
);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  logic [4:0] raw, stable;
  assign raw = {btn_right_i, btn_left_i, btn_back_i, btn_fwd_i, btn_power_i};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    robot_remote_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .btn_i   (raw[g]),
      .stable_o(stable[g])
    );
  end

  remote_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          pwr_prev_q, pwr_prev_d;
  logic          motor_on_q, motor_on_d;
  logic [2:0]    move_q, move_d;
  logic          led_power_q, led_power_d;
  logic          led_obs_q, led_obs_d;
  logic          err_q, err_d;
  logic          press;
  logic          timeout;

  assign press   = stable[0] & ~pwr_prev_q;
  assign timeout = (timer_q == TW'(START_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pwr_prev_d = stable[0];
    case (state_q)
      ST_OFF: if (press) begin
        state_d = ST_STARTING;
        timer_d = '0;
      end
      ST_STARTING: begin
        if (link.motor_status_i) state_d = ST_ON;
        else if (timeout)        state_d = ST_FAULT;
        else                     timer_d = timer_q + TW'(1);
      end
      // A stop request wins over a simultaneous loss of motor status.
      ST_ON: begin
        if (press) begin
          state_d = ST_STOPPING;
          timer_d = '0;
        end else if (!link.motor_status_i) begin
          state_d = ST_FAULT;
        end
      end
      ST_STOPPING: begin
        if (!link.motor_status_i) state_d = ST_OFF;
        else if (timeout)         state_d = ST_FAULT;
        else                      timer_d = timer_q + TW'(1);
      end
      ST_FAULT: if (press) state_d = ST_OFF;
      default:  state_d = ST_OFF;
    endcase

    lock_d = '0;
    if (state_d == ST_ON) begin
      if (link.tracker_status_i) lock_d = LW'(LOCKOUT_CYCLES);
      else if (lock_q != '0)     lock_d = lock_q - LW'(1);
    end

    motor_on_d  = (state_d == ST_STARTING) || (state_d == ST_ON);
    led_power_d = (state_d == ST_ON);
    err_d       = (state_d == ST_FAULT);
    led_obs_d   = (lock_d != '0);
    move_d      = (state_d == ST_ON)
                ? encode_move(stable[1], stable[2], stable[3], stable[4], lock_d != '0)
                : MOVE_STOP;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_OFF;
      timer_q     <= '0;
      lock_q      <= '0;
      pwr_prev_q  <= 1'b0;
      motor_on_q  <= 1'b0;
      move_q      <= MOVE_STOP;
      led_power_q <= 1'b0;
      led_obs_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lock_q      <= lock_d;
      pwr_prev_q  <= pwr_prev_d;
      motor_on_q  <= motor_on_d;
      move_q      <= move_d;
      led_power_q <= led_power_d;
      led_obs_q   <= led_obs_d;
      err_q       <= err_d;
    end
  end

  assign link.motor_on_o = motor_on_q;
  assign link.move_o     = move_q;
  assign led_power_o     = led_power_q;
  assign led_obstacle_o  = led_obs_q;
  assign err_o           = err_q;
endmodule

// File: tb/tb_robot_remote.sv
// tb/tb_robot_remote.sv - bench for robot_remote with a cycle-level reference model
module tb_robot_remote;
  localparam int DB = 4;
  localparam int TO = 8;
  localparam int LK = 16;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b1;
  logic btn_power_i = 0, btn_fwd_i = 0, btn_back_i = 0, btn_left_i = 0, btn_right_i = 0;
  logic led_power_o, led_obstacle_o, err_o;

  robot_remote_if link();

  robot_remote #(.DEBOUNCE_CYCLES(DB), .START_TIMEOUT(TO), .LOCKOUT_CYCLES(LK)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .btn_power_i   (btn_power_i),
    .btn_fwd_i     (btn_fwd_i),
    .btn_back_i    (btn_back_i),
    .btn_left_i    (btn_left_i),
    .btn_right_i   (btn_right_i),
    .link          (link),
    .led_power_o   (led_power_o),
    .led_obstacle_o(led_obstacle_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: 0 OFF, 1 STARTING, 2 ON, 3 STOPPING, 4 FAULT
  int m_st = 0, m_timer = 0, m_lock = 0;
  int m_run[5];
  bit m_s1[5], m_s2[5], m_stab[5];
  bit m_press = 0;
  bit m_motor_on = 0, m_led_pwr = 0, m_led_obs = 0, m_err = 0;
  int m_move = 0;

  function automatic int model_move(input bit f, input bit b, input bit l, input bit r, input int lock);
    int n;
    n = int'(f) + int'(b) + int'(l) + int'(r);
    if (n != 1) return 0;
    if (f) return (lock != 0) ? 0 : 7;
    if (b) return 3;
    if (l) return 5;
    return 6;
  endfunction

  always @(posedge clk_i or negedge rstn_i) begin
    bit raw[5];
    bit new_press;
    if (!rstn_i) begin
      m_st = 0; m_timer = 0; m_lock = 0; m_press = 0;
      m_motor_on = 0; m_led_pwr = 0; m_led_obs = 0; m_err = 0; m_move = 0;
      for (int b = 0; b < 5; b++) begin
        m_run[b] = 0; m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0;
      end
    end else begin
      raw = '{btn_power_i, btn_fwd_i, btn_back_i, btn_left_i, btn_right_i};
      case (m_st)
        0: if (m_press) begin m_st = 1; m_timer = 0; end
        1: if (link.motor_status_i) m_st = 2;
           else if (m_timer == TO - 1) m_st = 4;
           else m_timer++;
        2: if (m_press) begin m_st = 3; m_timer = 0; end
           else if (!link.motor_status_i) m_st = 4;
        3: if (!link.motor_status_i) m_st = 0;
           else if (m_timer == TO - 1) m_st = 4;
           else m_timer++;
        default: if (m_press) m_st = 0;
      endcase
      if (m_st != 2) m_lock = 0;
      else if (link.tracker_status_i) m_lock = LK;
      else if (m_lock > 0) m_lock--;
      m_motor_on = (m_st == 1 || m_st == 2);
      m_led_pwr  = (m_st == 2);
      m_err      = (m_st == 4);
      m_led_obs  = (m_lock != 0);
      m_move     = (m_st == 2) ? model_move(m_stab[1], m_stab[2], m_stab[3], m_stab[4], m_lock) : 0;
      new_press = 0;
      for (int b = 0; b < 5; b++) begin
        if (m_s2[b] != m_stab[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_stab[b] = m_s2[b];
            m_run[b]  = 0;
            if (b == 0 && m_stab[0]) new_press = 1;
          end
        end else begin
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
      m_press = new_press;
    end
  end

  always @(negedge clk_i) begin
    logic [6:0] act, exp;
    act = {link.motor_on_o, link.move_o, led_power_o, led_obstacle_o, err_o};
    exp = {m_motor_on, 3'(m_move), m_led_pwr, m_led_obs, m_err};
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL cycle_compare t=%0t got on/move/pwr/obs/err=%b expected %b", $time, act, exp);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_move(input logic [2:0] val, output int lat);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (link.move_o == val) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic int outs();
    return int'({link.motor_on_o, link.move_o, led_power_o, led_obstacle_o, err_o});
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int on_at, off_at, lat, n, nz, on_cnt, clr, hold;
    link.motor_status_i   = 0;
    link.tracker_status_i = 0;
    #1 rstn_i = 0;
    tick(2);
    check("reset_outputs", outs(), 0);
    rstn_i = 1;
    tick(3);

    // Power on, robot answers 3 cycles after motor_on
    btn_power_i = 1; on_at = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_i);
      if (link.motor_on_o && on_at == 0) on_at = i;
      if (on_at != 0 && i == on_at + 3) link.motor_status_i = 1;
    end
    btn_power_i = 0;
    @(negedge clk_i);
    check("start_latency", on_at, 7);
    check("led_power_on", int'(led_power_o), 1);
    tick(10);

    btn_fwd_i = 1;
    wait_move(3'b111, lat); check("fwd_latency", lat, 7);
    btn_fwd_i = 0;
    wait_move(3'b000, lat); check("fwd_release", lat, 7);
    btn_fwd_i = 1; btn_left_i = 1;
    tick(12); check("fwd_left_combo", int'(link.move_o), 0);
    btn_fwd_i = 0; btn_left_i = 0;
    tick(10);

    btn_left_i = 1; nz = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) btn_left_i = 0;
      @(negedge clk_i);
      if (link.move_o != 0) nz++;
    end
    check("left_glitch", nz, 0);

    btn_fwd_i = 1;
    tick(10); check("fwd_before_lock", int'(link.move_o), 7);
    link.tracker_status_i = 1;
    @(negedge clk_i);
    link.tracker_status_i = 0;
    n = 0; nz = 0;
    for (int i = 0; i < 30; i++) begin
      if (!led_obstacle_o) break;
      n++;
      if (link.move_o != 0) nz++;
      @(negedge clk_i);
    end
    check("lock_len", n, 16);
    check("lock_move_blocked", nz, 0);
    check("fwd_after_lock", int'(link.move_o), 7);

    link.tracker_status_i = 1;
    @(negedge clk_i);
    link.tracker_status_i = 0;
    btn_fwd_i = 0; btn_back_i = 1;
    wait_move(3'b011, lat); check("back_in_lock", lat, 7);
    check("lock_still_on", int'(led_obstacle_o), 1);
    btn_back_i = 0;
    tick(25);

    // Stop request; robot drops status 2 cycles after motor_on falls
    btn_power_i = 1; off_at = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_i);
      if (!link.motor_on_o && off_at == 0) begin
        off_at = i;
        check("stop_outputs", int'({link.move_o, led_power_o}), 0);
      end
      if (off_at != 0 && i == off_at + 2) link.motor_status_i = 0;
    end
    btn_power_i = 0;
    tick(12);
    check("stop_latency", off_at, 7);
    check("off_after_stop", int'({link.motor_on_o, err_o, led_power_o}), 0);

    btn_power_i = 1; on_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_i);
      if (link.motor_on_o) on_cnt++;
      if (i == 10) btn_power_i = 0;
    end
    check("start_timeout_cycles", on_cnt, TO);
    check("fault_err", int'({err_o, link.motor_on_o}), 2);

    btn_power_i = 1; clr = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_i);
      if (!err_o && clr == 0) clr = i;
    end
    btn_power_i = 0;
    check("fault_clear", clr, 7);
    tick(12);
    check("off_after_fault", int'({err_o, link.motor_on_o}), 0);

    btn_power_i = 1;
    tick(9);
    check("starting_before_reset", int'(link.motor_on_o), 1);
    #2 rstn_i = 0;
    #1 check("reset_async", outs(), 0);
    btn_power_i = 0;
    tick(2);
    rstn_i = 1;
    tick(2);

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(negedge clk_i);
      if (hold == 0) begin
        hold = $urandom_range(1, 12);
        btn_power_i = ($urandom_range(0, 9) == 0);
        {btn_fwd_i, btn_back_i, btn_left_i, btn_right_i} = 4'b0;
        r = $urandom_range(0, 5);
        case (r)
          1: btn_fwd_i = 1;
          2: btn_back_i = 1;
          3: btn_left_i = 1;
          4: btn_right_i = 1;
          5: {btn_fwd_i, btn_back_i, btn_left_i, btn_right_i} = 4'($urandom_range(0, 15));
          default: ;
        endcase
      end else begin
        hold--;
      end
      link.tracker_status_i = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 31);
      if (r < 8) link.motor_status_i = link.motor_on_o;
      else if (r == 31) link.motor_status_i = ~link.motor_status_i;
      if ($urandom_range(0, 999) == 0) begin
        #2 rstn_i = 0;
        #1 rstn_i = 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
